clk_rate_controller: RTL
========================

// Module: clk_rate_controller
// PURPOSE
//   Rate-select controller for the switch-selected clock divider. Owns the 4-bit
//   divider select and changes it only on a divider period boundary (div_tick),
//   so the divided clock never produces a runt pulse. Supports manual step
//   up/down from button pulses and an automatic ping-pong sweep over all rates.
//   Sits between the board button/mode inputs and the divider's select port.
// PARAMETERS
//   SEL_W     4   width of the rate select
//   SEL_MAX   15  highest legal select value (the lowest legal value is 0)
//   SEL_RST   0   select value loaded at reset
//   DWELL     8   div_ticks spent on each rate in sweep mode (>=1)
// PORTS
//   clk       in   1      system clock
//   rst       in   1      synchronous, active-high reset
//   btn_up    in   1      1-cycle pulse, already synchronised: request sel+1
//   btn_dn    in   1      1-cycle pulse, already synchronised: request sel-1
//   mode      in   1      0 = manual, 1 = auto sweep (level)
//   div_tick  in   1      1-cycle pulse from the divider at each output period boundary
//   sel       out  SEL_W  select driven to the divider
//   busy      out  1      a manual change is pending, waiting for div_tick
//   step      out  1      1-cycle pulse in the cycle after sel changes
//   sweeping  out  1      high while in the SWEEP state
// BEHAVIOUR
//   Reset (sync, any state): sel=SEL_RST, state=IDLE, busy=0, step=0, sweeping=0,
//     pend=SEL_RST, dwell_cnt=0, dir=up. Reset has priority over every other input.
//   States: IDLE, PEND, SWEEP. All outputs are registered.
//   IDLE (mode=0):
//     - btn_up only: pend=min(sel+1,SEL_MAX). btn_dn only: pend=max(sel-1,0).
//     - btn_up and btn_dn together: ignored, stay in IDLE.
//     - If the saturated pend equals sel, stay in IDLE (no busy, no step).
//     - Otherwise go to PEND; busy=1 from the next cycle.
//     - A div_tick in the same cycle as the button does not commit the change.
//   PEND: buttons are ignored. On the first div_tick sampled in PEND: sel<=pend,
//     busy<=0, step pulses 1 cycle, go to IDLE. Latency: a button in cycle N sets
//     busy in N+1; sel updates on the edge after the first div_tick in >=N+1.
//   mode=1 seen in IDLE or PEND: go to SWEEP; any pending request is discarded
//     (busy<=0, sel unchanged), dwell_cnt=0, dir=up, sweeping=1.
//   SWEEP: buttons are ignored. Each div_tick increments dwell_cnt. When
//     div_tick arrives with dwell_cnt==DWELL-1: dwell_cnt<=0, sel steps by 1
//     in dir, step pulses.
//     - Ping-pong ends: a step that lands on SEL_MAX sets dir=down; a step that
//       lands on 0 sets dir=up.
//     - If sel is already at an end when the step fires, move away from that end
//       (flip dir first). sel never leaves 0..SEL_MAX.
//   mode=0 seen in SWEEP: go to IDLE next cycle, sel held, sweeping=0,
//     dwell_cnt cleared.
//   The mode input is sampled every cycle and takes priority over buttons and
//     div_tick in that cycle.
//   sel changes only in the cycle after a sampled div_tick (or on reset).
// TESTING
//   1 rst=1 two cycles, release -> sel=0, busy=0, step=0, sweeping=0.
//   2 mode=0, btn_up at cycle 3, div_tick at cycle 8 -> busy=1 for cycles 4..8,
//     sel=1 and step=1 at cycle 9, busy=0.
//   3 sel=15, btn_up -> stays IDLE, busy never rises; btn_up+btn_dn same cycle
//     -> no change; btn_dn during PEND -> ignored, committed value is the first.
//   4 DWELL=2, mode=1 from sel=14, tick every 4 cycles -> sel 15,14,13 on every
//     2nd tick; step pulses each change; from sel=0, first step gives 1.
//   5 busy=1 (PEND), then rst=1 before div_tick -> sel=SEL_RST, busy=0 next
//     cycle; a later div_tick causes no change.
//   6 PEND, then mode=1 -> busy=0, sel unchanged, sweeping=1; mode=0 -> IDLE,
//     sel held.

Source files
------------

// File: rtl/clk_rate_controller.sv
// rtl/clk_rate_controller.sv - rate-select controller for the switch-selected clock divider
module clk_rate_controller #(
  parameter int SEL_W   = 4,
  parameter int SEL_MAX = 15,
  parameter int SEL_RST = 0,
  parameter int DWELL   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             mode,
  input  logic             div_tick,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             step,
  output logic             sweeping
);

  // dwell counter wide enough to hold DWELL-1 even when DWELL is 1
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] SWEEP = 2'd2;

  localparam logic [SEL_W-1:0] MAX_V   = SEL_W'(SEL_MAX);
  localparam logic [SEL_W-1:0] RST_V   = SEL_W'(SEL_RST);
  localparam logic [SEL_W-1:0] ZERO_V  = '0;
  localparam logic [SEL_W-1:0] ONE_V   = SEL_W'(1);
  localparam logic [DW-1:0]    DWELL_L = DW'(DWELL - 1);

  logic [1:0]       state;
  logic [SEL_W-1:0] pend;
  logic [DW-1:0]    dwell_cnt;
  logic             dir_up;

  logic [SEL_W-1:0] sat_up;
  logic [SEL_W-1:0] sat_dn;
  logic [SEL_W-1:0] req_sel;
  logic             req_valid;
  logic             at_max;
  logic             at_min;
  logic             eff_up;
  logic [SEL_W-1:0] sweep_sel;
  logic             sweep_dir_up;

  // manual request target and next ping-pong position, both saturated to the legal range
  always_comb begin
    at_max    = (sel == MAX_V);
    at_min    = (sel == ZERO_V);
    sat_up    = at_max ? sel : sel + ONE_V;
    sat_dn    = at_min ? sel : sel - ONE_V;
    req_sel   = btn_up ? sat_up : sat_dn;
    req_valid = (btn_up ^ btn_dn) && (req_sel != sel);

    // at an end the direction flips before the step so sel never leaves the range
    eff_up    = dir_up ? !at_max : at_min;
    sweep_sel = eff_up ? sel + ONE_V : sel - ONE_V;
    if (sweep_sel == MAX_V) begin
      sweep_dir_up = 1'b0;
    end else if (sweep_sel == ZERO_V) begin
      sweep_dir_up = 1'b1;
    end else begin
      sweep_dir_up = eff_up;
    end
  end

  // control FSM: mode has priority, then commits on div_tick, then buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= RST_V;
      pend      <= RST_V;
      dwell_cnt <= '0;
      dir_up    <= 1'b1;
      busy      <= 1'b0;
      step      <= 1'b0;
      sweeping  <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (mode) begin
            state     <= SWEEP;
            sweeping  <= 1'b1;
            dwell_cnt <= '0;
            dir_up    <= 1'b1;
            busy      <= 1'b0;
          end else if (req_valid) begin
            // a div_tick in this same cycle is deliberately not used to commit
            pend  <= req_sel;
            busy  <= 1'b1;
            state <= PEND;
          end
        end
        PEND: begin
          if (mode) begin
            // pending request is dropped; sel stays where it was
            state     <= SWEEP;
            sweeping  <= 1'b1;
            dwell_cnt <= '0;
            dir_up    <= 1'b1;
            busy      <= 1'b0;
          end else if (div_tick) begin
            sel   <= pend;
            busy  <= 1'b0;
            step  <= 1'b1;
            state <= IDLE;
          end
        end
        SWEEP: begin
          if (!mode) begin
            state     <= IDLE;
            sweeping  <= 1'b0;
            dwell_cnt <= '0;
          end else if (div_tick) begin
            if (dwell_cnt == DWELL_L) begin
              dwell_cnt <= '0;
              sel       <= sweep_sel;
              dir_up    <= sweep_dir_up;
              step      <= 1'b1;
            end else begin
              dwell_cnt <= dwell_cnt + DW'(1);
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          sweeping <= 1'b0;
        end
      endcase
    end
  end

endmodule
